// File: rtl/counter_sequencer_pkg.sv
// counter_sequencer_pkg: shared state type and constants for the counter sequencer.
// The sequencer counts wraps of an external 6-bit counter, so one wrap period is 64 cycles.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int COUNTER_PERIOD         = 64;
  localparam int DEFAULT_ITER_W         = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 80;

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: request, counter-control and result signals of the sequencer.
// The master side is the environment (requester, counter and result consumer).
// The slave side is the sequencer itself.
interface counter_sequencer_if
  import counter_sequencer_pkg::*;
#(
  parameter int ITER_W = DEFAULT_ITER_W
) ();

  logic              io_start_valid;
  logic              io_start_ready;
  logic [ITER_W-1:0] io_start_iters;
  logic              io_abort;
  logic              io_counter_reset;
  logic              io_counter_done;
  logic              io_output_valid;
  logic              io_output_ready;
  logic [ITER_W-1:0] io_output_iters;
  logic              io_output_aborted;
  logic              io_output_timeout;

  modport master (
    output io_start_valid,
    output io_start_iters,
    output io_abort,
    output io_counter_done,
    output io_output_ready,
    input  io_start_ready,
    input  io_counter_reset,
    input  io_output_valid,
    input  io_output_iters,
    input  io_output_aborted,
    input  io_output_timeout
  );

  modport slave (
    input  io_start_valid,
    input  io_start_iters,
    input  io_abort,
    input  io_counter_done,
    input  io_output_ready,
    output io_start_ready,
    output io_counter_reset,
    output io_output_valid,
    output io_output_iters,
    output io_output_aborted,
    output io_output_timeout
  );

endinterface

// File: rtl/counter_sequencer_watchdog.sv
// counter_sequencer_watchdog: counts RUN cycles since RUN entry or the last done pulse.
// Only instantiated when COUNTER_SEQUENCER_TIMEOUT_EN is defined.
// o_expired fires in the TIMEOUT_CYCLES-th quiet RUN cycle, so the run leaves RUN
// after exactly TIMEOUT_CYCLES cycles without a done pulse.
module counter_sequencer_watchdog
  import counter_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_kick,
  output logic o_expired
);

  localparam int            CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_atLimit;

  // Quiet-cycle counter: cleared outside RUN and on every done pulse, saturates at the limit
  always_ff @(posedge clock) begin
    if (reset || !i_run || i_kick) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign w_atLimit = (r_count == LIMIT);
  assign o_expired = i_run & ~i_kick & w_atLimit;

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: waits for a requested number of wraps of an external 6-bit counter,
// then reports how many done pulses were seen and whether the run was aborted or timed out.
// Optional watchdog: define COUNTER_SEQUENCER_TIMEOUT_EN to end runs that see no done pulse
// for TIMEOUT_CYCLES RUN cycles. Without it io_output_timeout is constantly 0.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int ITER_W         = DEFAULT_ITER_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  counter_sequencer_if.slave bus
);

  if (ITER_W < 1) begin : g_badIterW
    $error("ITER_W must be at least 1");
  end

  if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t            r_state;
  logic [ITER_W-1:0] r_tally;
  logic [ITER_W-1:0] r_target;
  logic              r_aborted;
  logic              r_timeout;

  state_t            w_stateNext;
  logic [ITER_W-1:0] w_tallyNext;
  logic [ITER_W-1:0] w_targetNext;
  logic              w_abortedNext;
  logic              w_timeoutNext;

  logic              w_inRun;
  logic              w_inReport;
  logic              w_doneInRun;
  logic [ITER_W-1:0] w_tallyInc;
  logic              w_wdExpired;

  assign w_inRun     = (r_state == RUN);
  assign w_inReport  = (r_state == REPORT);
  assign w_doneInRun = w_inRun & bus.io_counter_done;
  assign w_tallyInc  = r_tally + ITER_W'(1);

`ifdef COUNTER_SEQUENCER_TIMEOUT_EN
  counter_sequencer_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_run     (w_inRun),
    .i_kick    (w_doneInRun),
    .o_expired (w_wdExpired)
  );
`else
  assign w_wdExpired = 1'b0;
`endif

  // State and result registers; reset discards any run in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tally   <= '0;
      r_target  <= '0;
      r_aborted <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_tally   <= w_tallyNext;
      r_target  <= w_targetNext;
      r_aborted <= w_abortedNext;
      r_timeout <= w_timeoutNext;
    end
  end

  // Next-state logic: accept in IDLE, count done pulses in RUN, hold the result in REPORT
  always_comb begin
    w_stateNext   = r_state;
    w_tallyNext   = r_tally;
    w_targetNext  = r_target;
    w_abortedNext = r_aborted;
    w_timeoutNext = r_timeout;

    unique case (r_state)
      IDLE: begin
        if (bus.io_start_valid) begin
          w_targetNext  = bus.io_start_iters;
          w_tallyNext   = '0;
          w_abortedNext = 1'b0;
          w_timeoutNext = 1'b0;
          w_stateNext   = (bus.io_start_iters == '0) ? REPORT : RUN;
        end
      end

      RUN: begin
        if (w_doneInRun) begin
          w_tallyNext = w_tallyInc;
        end
        if (bus.io_abort) begin
          w_abortedNext = 1'b1;
          w_stateNext   = REPORT;
        end else if (w_doneInRun && (w_tallyInc == r_target)) begin
          w_stateNext = REPORT;
        end else if (w_wdExpired) begin
          w_timeoutNext = 1'b1;
          w_stateNext   = REPORT;
        end
      end

      REPORT: begin
        if (bus.io_output_ready) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign bus.io_start_ready    = (r_state == IDLE);
  assign bus.io_counter_reset  = reset | ~w_inRun;
  assign bus.io_output_valid   = w_inReport;
  assign bus.io_output_iters   = w_inReport ? r_tally : '0;
  assign bus.io_output_aborted = w_inReport & r_aborted;
  assign bus.io_output_timeout = w_inReport & r_timeout;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed bench with a real 6-bit wrap counter and a run-level
// model that predicts results from accept time, wrap period and abort/reset times.
module tb_counter_sequencer;
  import counter_sequencer_pkg::*;

  localparam int ITER_W  = DEFAULT_ITER_W;
  localparam int TIMEOUT = DEFAULT_TIMEOUT_CYCLES;
`ifdef COUNTER_SEQUENCER_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic forceDoneLow = 1'b0;
  logic [5:0] cnt = 6'd0;
  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;

  counter_sequencer_if #(.ITER_W(ITER_W)) bus ();

  counter_sequencer #(
    .ITER_W         (ITER_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Cycle number c covers the interval after the c-th rising edge
  always @(posedge clock) cyc <= cyc + 1;

  // External 6-bit wrap counter driven by the sequencer's counter reset
  always @(posedge clock) begin
    if (bus.io_counter_reset) cnt <= 6'd0;
    else cnt <= cnt + 6'd1;
  end

  assign bus.io_counter_done = (cnt == 6'd63) && !forceDoneLow;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic gotoCycle(input int c);
    while (cyc < c) nextCycle();
  endtask

  task automatic applyStimulus(input logic sv, input int iters, input logic ab, input logic rdy);
    bus.io_start_valid  = sv;
    bus.io_start_iters  = ITER_W'(iters);
    bus.io_abort        = ab;
    bus.io_output_ready = rdy;
  endtask

  // Run-level model and event log
  typedef enum int {M_IDLE, M_RUN, M_REPORT} mPhase_t;
  mPhase_t mPhase = M_IDLE;
  int  mAcc = 0;
  int  mTarget = 0;
  int  mResIters = 0;
  bit  mResAborted = 0;
  bit  mResTimeout = 0;
  bit  checkEn = 0;

  int  doneLog[$];
  int  riseCycle = -1;
  int  riseIters = -1;
  int  riseAborted = -1;
  int  riseTimeout = -1;
  bit  cntResetLowSeen = 0;
  bit  prevValid = 0;

  // Compare every cycle against the model, log events, then advance the model
  always @(negedge clock) begin
    int elapsed;
    int pulses;
    int lastRef;
    bit doneNow;
    bit expValid;
    expValid = (mPhase == M_REPORT);
    if (checkEn) begin
      checkOutput("start_ready", bus.io_start_ready, int'(mPhase == M_IDLE));
      checkOutput("counter_reset", bus.io_counter_reset, int'(reset || mPhase != M_RUN));
      checkOutput("output_valid", bus.io_output_valid, int'(expValid));
      checkOutput("output_iters", bus.io_output_iters, expValid ? mResIters : 0);
      checkOutput("output_aborted", bus.io_output_aborted, expValid ? int'(mResAborted) : 0);
      checkOutput("output_timeout", bus.io_output_timeout, expValid ? int'(mResTimeout) : 0);
    end

    if (bus.io_counter_done === 1'b1) doneLog.push_back(cyc);
    if (bus.io_counter_reset === 1'b0) cntResetLowSeen = 1'b1;
    if (bus.io_output_valid === 1'b1 && !prevValid) begin
      riseCycle   = cyc;
      riseIters   = int'(bus.io_output_iters);
      riseAborted = int'(bus.io_output_aborted);
      riseTimeout = int'(bus.io_output_timeout);
    end
    prevValid = (bus.io_output_valid === 1'b1);

    if (reset) begin
      mPhase = M_IDLE;
    end else begin
      case (mPhase)
        M_IDLE: begin
          if (bus.io_start_valid) begin
            mAcc    = cyc;
            mTarget = int'(bus.io_start_iters);
            mResIters = 0; mResAborted = 0; mResTimeout = 0;
            mPhase  = (mTarget == 0) ? M_REPORT : M_RUN;
          end
        end
        M_RUN: begin
          elapsed = cyc - mAcc;
          doneNow = !forceDoneLow && (elapsed % COUNTER_PERIOD == 0);
          pulses  = forceDoneLow ? 0 : elapsed / COUNTER_PERIOD;
          lastRef = mAcc + pulses * COUNTER_PERIOD;
          if (bus.io_abort) begin
            mResIters = pulses; mResAborted = 1; mResTimeout = 0;
            mPhase = M_REPORT;
          end else if (doneNow && pulses == mTarget) begin
            mResIters = pulses; mResAborted = 0; mResTimeout = 0;
            mPhase = M_REPORT;
          end else if (WD_EN && !doneNow && (cyc - lastRef) == TIMEOUT) begin
            mResIters = pulses; mResAborted = 0; mResTimeout = 1;
            mPhase = M_REPORT;
          end
        end
        default: begin
          if (bus.io_output_ready) mPhase = M_IDLE;
        end
      endcase
    end
    if (reset) checkEn = 1'b1;
  end

  task automatic clearLog();
    doneLog.delete();
    riseCycle = -1;
    riseIters = -1;
    riseAborted = -1;
    riseTimeout = -1;
    cntResetLowSeen = 1'b0;
  endtask

  int expDone[3] = '{74, 138, 202};
  int c0;
  int stable;

  initial begin
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(4);
    reset = 1'b0;
    clearLog();

    // iters=3 accepted in cycle 10 with ready held high
    gotoCycle(10);
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(204);
    checkOutput("t1 idle again", bus.io_start_ready, 1);
    gotoCycle(206);
    checkOutput("t1 done count", doneLog.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput("t1 done cycle", (doneLog.size() > i) ? doneLog[i] : -1, expDone[i]);
    checkOutput("t1 valid cycle", riseCycle, 203);
    checkOutput("t1 iters", riseIters, 3);
    checkOutput("t1 aborted", riseAborted, 0);
    checkOutput("t1 timeout", riseTimeout, 0);

    // iters=0 goes straight to the result
    clearLog();
    c0 = cyc;
    applyStimulus(1'b1, 0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 4);
    checkOutput("t2 valid cycle", riseCycle, c0 + 1);
    checkOutput("t2 iters", riseIters, 0);
    checkOutput("t2 counter reset held", int'(cntResetLowSeen), 0);

    // abort while idle is ignored
    clearLog();
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    repeat (3) nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("t3 idle abort no result", riseCycle, -1);
    checkOutput("t3 idle abort ready", bus.io_start_ready, 1);

    // iters=5 aborted at N+100 after one wrap
    clearLog();
    c0 = cyc;
    applyStimulus(1'b1, 5, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 100);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 104);
    checkOutput("t4 valid cycle", riseCycle, c0 + 101);
    checkOutput("t4 iters", riseIters, 1);
    checkOutput("t4 aborted", riseAborted, 1);

    // abort coincident with the second done pulse
    clearLog();
    c0 = cyc;
    applyStimulus(1'b1, 5, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 128);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 132);
    checkOutput("t5 valid cycle", riseCycle, c0 + 129);
    checkOutput("t5 iters", riseIters, 2);
    checkOutput("t5 aborted", riseAborted, 1);

    // result held 20 cycles with ready low while new requests are offered
    clearLog();
    c0 = cyc;
    applyStimulus(1'b1, 1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    gotoCycle(c0 + 65);
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.io_output_valid === 1'b1 && bus.io_output_iters === 8'd1 &&
          bus.io_output_aborted === 1'b0 && bus.io_start_ready === 1'b0) stable++;
      nextCycle();
    end
    checkOutput("t6 held cycles", stable, 20);
    applyStimulus(1'b1, 7, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("t6 no accept in handshake", bus.io_start_ready, 1);
    nextCycle();

    // reset in the middle of a run, then a normal iters=1 run
    clearLog();
    c0 = cyc;
    applyStimulus(1'b1, 3, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 70);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("t7 ready after reset", bus.io_start_ready, 1);
    checkOutput("t7 counter reset", bus.io_counter_reset, 1);
    checkOutput("t7 no valid", bus.io_output_valid, 0);
    c0 = cyc + 2;
    gotoCycle(c0);
    clearLog();
    applyStimulus(1'b1, 1, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 67);
    checkOutput("t7 valid cycle", riseCycle, c0 + 65);
    checkOutput("t7 iters", riseIters, 1);

    // done input forced low
    clearLog();
    forceDoneLow = 1'b1;
    c0 = cyc;
    applyStimulus(1'b1, 2, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
`ifdef COUNTER_SEQUENCER_TIMEOUT_EN
    gotoCycle(c0 + 84);
    checkOutput("t8 timeout valid cycle", riseCycle, c0 + 81);
    checkOutput("t8 timeout flag", riseTimeout, 1);
    checkOutput("t8 timeout iters", riseIters, 0);
    checkOutput("t8 timeout aborted", riseAborted, 0);
`else
    gotoCycle(c0 + 150);
    checkOutput("t8 no report", riseCycle, -1);
    checkOutput("t8 timeout low", bus.io_output_timeout, 0);
    checkOutput("t8 still running", bus.io_counter_reset, 0);
    c0 = cyc;
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    gotoCycle(c0 + 4);
    checkOutput("t8 abort valid cycle", riseCycle, c0 + 1);
    checkOutput("t8 abort flag", riseAborted, 1);
    checkOutput("t8 abort iters", riseIters, 0);
`endif
    forceDoneLow = 1'b0;
    repeat (3) nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter ITER_W, default 8, width of iteration request and result.
REQ-002 Parameter TIMEOUT_CYCLES, default 80, watchdog limit in cycles; used only with COUNTER_SEQUENCER_TIMEOUT_EN.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_start_valid  input  1  run request.
REQ-006 io_start_ready  output  1  block can accept a request.
REQ-007 io_start_iters  input  ITER_W  number of counter wraps to wait for.
REQ-008 io_abort  input  1  terminate the current run early.
REQ-009 io_counter_reset  output  1  drives the 6-bit counter's io_input_reset.
REQ-010 io_counter_done  input  1  the counter's io_output_done, a one-cycle pulse at count 63.
REQ-011 io_output_valid  output  1  result available.
REQ-012 io_output_ready  input  1  result consumed.
REQ-013 io_output_iters  output  ITER_W  number of done pulses counted in the run.
REQ-014 io_output_aborted  output  1  run ended by io_abort.
REQ-015 io_output_timeout  output  1  run ended by watchdog.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, RUN and REPORT.
REQ-017 io_start_ready SHALL be 1 only in IDLE.
REQ-018 The block SHALL accept a request in IDLE when io_start_valid=1; it SHALL latch io_start_iters, clear the done tally and flags, and enter RUN next cycle.
REQ-019 A request with iters=0 SHALL go from IDLE directly to REPORT with io_output_iters=0.
REQ-020 io_counter_reset SHALL be 1 whenever reset=1 or state!=RUN, and 0 in RUN, so the counter holds 0 outside RUN.
REQ-021 Timing for a request accepted in cycle N: the counter shows 0 in N+1, and done pulses occur in cycles N+64k.
REQ-022 In RUN, each io_counter_done=1 cycle SHALL increment the tally by 1; the tally is ITER_W wide with no wrap, because the run ends at tally==iters.
REQ-023 When the done pulse brings the tally to the latched iters, the FSM SHALL enter REPORT in the next cycle (N+64*iters+1).
REQ-024 io_counter_done outside RUN SHALL be ignored.
REQ-025 io_abort=1 in RUN SHALL move the FSM to REPORT next cycle with io_output_aborted=1 and io_output_iters equal to the partial tally.
REQ-026 If a done pulse and io_abort occur in the same cycle, the done pulse SHALL be counted and aborted=1 SHALL still be reported.
REQ-027 io_abort outside RUN SHALL be ignored.
REQ-028 In REPORT, io_output_valid=1 SHALL hold, and io_output_iters/aborted/timeout SHALL be stable until io_output_ready=1.
REQ-029 The FSM SHALL return to IDLE in the cycle after the handshake.
REQ-030 No new request SHALL be accepted in the handshake cycle.
REQ-031 io_output_iters/aborted/timeout SHALL be 0 whenever io_output_valid=0.

Reset
REQ-032 reset=1 SHALL force IDLE from any state in the next cycle, including mid-RUN and mid-REPORT, discarding the run with no result.
REQ-033 After reset: io_start_ready=1, io_output_valid=0, io_output_iters=0, io_output_aborted=0, io_output_timeout=0, io_counter_reset=1, tally=0, watchdog=0.

Configuration
REQ-034 With macro COUNTER_SEQUENCER_TIMEOUT_EN defined, a watchdog SHALL count RUN cycles since RUN entry or the last done pulse.
REQ-035 With the macro defined, reaching TIMEOUT_CYCLES without a done pulse SHALL move the FSM to REPORT with io_output_timeout=1.
REQ-036 With the macro defined, abort SHALL take priority over timeout in the same cycle.
REQ-037 Without the macro, the watchdog logic SHALL be absent, io_output_timeout SHALL be tied to 0, and the port list SHALL be unchanged.

Structure
REQ-038 Package counter_sequencer_pkg SHALL hold the state enum, COUNTER_PERIOD=64, and the default ITER_W and TIMEOUT_CYCLES constants.
REQ-039 The watchdog SHALL be a sub-module counter_sequencer_watchdog, instantiated only under COUNTER_SEQUENCER_TIMEOUT_EN.
REQ-040 The bench SHALL connect a real 6-bit wrap counter to io_counter_reset and io_counter_done.

Verification
REQ-041 Request iters=3 accepted in cycle 10 with ready held 1 -> done pulses in cycles 74, 138 and 202; valid=1 from cycle 203 with iters=3, aborted=0, timeout=0; idle again in cycle 204.
REQ-042 Request iters=0 -> REPORT in the next cycle with iters=0 and io_counter_reset never deasserted.
REQ-043 Request iters=5 with io_abort in cycle N+100 -> REPORT with iters=1 and aborted=1; abort coincident with a done pulse at N+128 -> iters=2, aborted=1.
REQ-044 REPORT with io_output_ready low for 20 cycles -> valid and data stable for all 20 cycles, and io_start_valid=1 not accepted.
REQ-045 reset pulsed in RUN at N+70 -> IDLE next cycle, io_counter_reset=1, and a following iters=1 request completes normally at M+65.
REQ-046 With COUNTER_SEQUENCER_TIMEOUT_EN and the done input forced 0 -> REPORT after 80 RUN cycles with timeout=1 and iters=0; without the macro -> no REPORT and timeout stays 0.
